// File: rtl/cv3_column_feeder.sv
`default_nettype none
// cv3_column_feeder: streams kernel columns then image columns from two read ports to a column consumer.
// Rev 1.0

module cv3_column_feeder #(
  parameter int DATA_WIDTH     = 16,
  parameter int KERNEL_SIZE    = 3,
  parameter int INPUT_COL_SIZE = 12,
  parameter int IMAGE_WIDTH    = 12
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                start,
  input  logic                                                skip_kernel,
  input  logic                                                pause,
  output logic                                                busy,
  output logic                                                done,
  output logic                                                kern_rd_en,
  output logic [((KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1)-1:0] kern_rd_addr,
  input  logic signed [KERNEL_SIZE-1:0][DATA_WIDTH-1:0]       kern_rd_data,
  output logic                                                img_rd_en,
  output logic [((IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1)-1:0] img_rd_addr,
  input  logic signed [INPUT_COL_SIZE-1:0][DATA_WIDTH-1:0]    img_rd_data,
  output logic                                                kernel_load,
  output logic                                                valid_out,
  output logic signed [KERNEL_SIZE-1:0][DATA_WIDTH-1:0]       kernel_column,
  output logic signed [INPUT_COL_SIZE-1:0][DATA_WIDTH-1:0]    input_column
);

  localparam int KAW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int IAW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int CW  = (KAW > IAW) ? KAW : IAW;
  localparam logic [CW-1:0] K_LAST = CW'(KERNEL_SIZE - 1);
  localparam logic [CW-1:0] I_LAST = CW'(IMAGE_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_K = 2'd1,
    FEED   = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            kern_vld;
  logic            img_vld;
  logic            done_r;

  // Read enables decode the registered state; pause gates FEED reads in the same cycle.
  assign kern_rd_en   = (state == LOAD_K);
  assign kern_rd_addr = cnt[KAW-1:0];
  assign img_rd_en    = (state == FEED) && !pause;
  assign img_rd_addr  = cnt[IAW-1:0];

  assign kernel_load   = kern_vld;
  assign valid_out     = kern_vld || img_vld;
  assign done          = done_r;
  assign busy          = (state != IDLE) || done_r;
  assign kernel_column = kern_rd_data;
  assign input_column  = img_rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      kern_vld <= 1'b0;
      img_vld  <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      kern_vld <= kern_rd_en;
      img_vld  <= img_rd_en;
      done_r   <= img_rd_en && (cnt == I_LAST);
      case (state)
        IDLE: begin
          // The done cycle still counts as busy, so a start there is dropped.
          if (start && !done_r) begin
            cnt   <= '0;
            state <= skip_kernel ? FEED : LOAD_K;
          end
        end
        LOAD_K: begin
          if (cnt == K_LAST) begin
            cnt   <= '0;
            state <= FEED;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FEED: begin
          if (!pause) begin
            if (cnt == I_LAST) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
